// File: rtl/data_sync_pkg.sv
// Shared constants and types for the data_sync bus synchroniser.
package data_sync_pkg;

  localparam int DATA_SYNC_MIN_STAGES = 2;
  localparam int DATA_SYNC_MAX_STAGES = 4;
  localparam int DATA_SYNC_BUS_WIDTH  = 8;

  typedef enum logic {
    LEVEL  = 1'b0,
    TOGGLE = 1'b1
  } sync_mode_e;

  function automatic bit stages_legal(input int n);
    return (n >= DATA_SYNC_MIN_STAGES) && (n <= DATA_SYNC_MAX_STAGES);
  endfunction

endpackage

// File: rtl/data_sync_bit_sync.sv
// Generic N-stage, WIDTH-bit flop-chain synchroniser for single-bit crossings.
module bit_sync
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int WIDTH      = 1
) (
  input  logic             Dclk,
  input  logic             Drst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  if (NUM_STAGES < DATA_SYNC_MIN_STAGES) begin : g_bad_depth
    $error("bit_sync: NUM_STAGES must be at least %0d", DATA_SYNC_MIN_STAGES);
  end

  logic [NUM_STAGES-1:0][WIDTH-1:0] stage_q;

  // NOTE: every flop in the chain uses <= so each stage samples the previous
  // stage's old value; blocking assignments would collapse the chain.
  always_ff @(posedge Dclk or negedge Drst_n) begin
    if (!Drst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[NUM_STAGES-2:0], async_i};
    end
  end

  assign sync_o = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// Bus synchroniser: only the enable crosses through a flop chain; its edge captures the bus once.
// Define DATA_SYNC_TOGGLE_EN for toggle mode (both enable edges capture).
module data_sync
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = DATA_SYNC_BUS_WIDTH
) (
  input  logic                 Dclk,
  input  logic                 Drst_n,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse
);

  if (!stages_legal(NUM_STAGES)) begin : g_bad_stages
    $error("data_sync: NUM_STAGES=%0d outside %0d..%0d",
           NUM_STAGES, DATA_SYNC_MIN_STAGES, DATA_SYNC_MAX_STAGES);
  end

  logic                 sync_en;
  logic                 edge_q;
  logic                 pulse_gen;
  logic                 pulse_q;
  logic [BUS_WIDTH-1:0] sync_bus_q;
  logic [BUS_WIDTH-1:0] sync_bus_d;

  bit_sync #(
    .NUM_STAGES (NUM_STAGES),
    .WIDTH      (1)
  ) u_en_sync (
    .Dclk    (Dclk),
    .Drst_n  (Drst_n),
    .async_i (bus_enable),
    .sync_o  (sync_en)
  );

`ifdef DATA_SYNC_TOGGLE_EN
  assign pulse_gen = sync_en ^ edge_q;
`else
  assign pulse_gen = sync_en & ~edge_q;
`endif

  // NOTE: the hold path is written out so the combinational block assigns
  // sync_bus_d on every path and no latch is inferred.
  always_comb begin
    sync_bus_d = sync_bus_q;
    if (pulse_gen) begin
      sync_bus_d = unsync_bus;
    end
  end

  always_ff @(posedge Dclk or negedge Drst_n) begin
    if (!Drst_n) begin
      edge_q     <= 1'b0;
      pulse_q    <= 1'b0;
      sync_bus_q <= '0;
    end else begin
      edge_q     <= sync_en;
      pulse_q    <= pulse_gen;
      sync_bus_q <= sync_bus_d;
    end
  end

  assign sync_bus     = sync_bus_q;
  assign enable_pulse = pulse_q;

endmodule

// File: tb/tb_data_sync.sv
// Self-checking bench for data_sync: two instances (2 and 3 stages) share one stimulus stream.
module tb_data_sync;
  import data_sync_pkg::*;

  logic       Dclk;
  logic       Drst_n;
  logic [7:0] unsync_bus;
  logic       bus_enable;
  logic [7:0] sync_bus2, sync_bus3;
  logic       pulse2, pulse3;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut2 (
    .Dclk(Dclk), .Drst_n(Drst_n), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .sync_bus(sync_bus2), .enable_pulse(pulse2)
  );

  data_sync #(.NUM_STAGES(3), .BUS_WIDTH(8)) dut3 (
    .Dclk(Dclk), .Drst_n(Drst_n), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .sync_bus(sync_bus3), .enable_pulse(pulse3)
  );

  initial Dclk = 1'b0;
  always #5 Dclk = ~Dclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the enable as sampled on each Dclk edge is delayed by N
  // edges; a rising (or, in toggle mode, any) change of that delayed stream
  // fires the strobe and captures the bus present at that edge.
  bit [5:0]   hist = '0;
  logic       m_p2 = 1'b0, m_p3 = 1'b0;
  logic [7:0] m_b2 = '0, m_b3 = '0;

  function automatic logic fire(input int n);
`ifdef DATA_SYNC_TOGGLE_EN
    return hist[n] != hist[n+1];
`else
    return hist[n] && !hist[n+1];
`endif
  endfunction

  always @(posedge Dclk or negedge Drst_n) begin
    if (!Drst_n) begin
      hist = '0;
      m_p2 = 1'b0; m_p3 = 1'b0;
      m_b2 = '0;   m_b3 = '0;
    end else begin
      hist = {hist[4:0], bus_enable};
      m_p2 = fire(2);
      m_p3 = fire(3);
      if (m_p2) m_b2 = unsync_bus;
      if (m_p3) m_b3 = unsync_bus;
    end
  end

  always @(negedge Dclk) begin
    if (chk_on) begin
      check("mdl_pulse_n2", {31'd0, pulse2}, {31'd0, m_p2});
      check("mdl_bus_n2",   {24'd0, sync_bus2}, {24'd0, m_b2});
      check("mdl_pulse_n3", {31'd0, pulse3}, {31'd0, m_p3});
      check("mdl_bus_n3",   {24'd0, sync_bus3}, {24'd0, m_b3});
    end
  end

  // One Dclk edge; returns 3 ns after the edge, clear of both clock edges.
  task automatic cyc();
    @(posedge Dclk);
    #3;
  endtask

  int n_p2, n_p3;
  logic [7:0] first_b2;

  task automatic run(input int n, input logic en, input logic [7:0] bus);
    bus_enable = en;
    unsync_bus = bus;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (pulse2) begin
        if (n_p2 == 0) first_b2 = sync_bus2;
        n_p2++;
      end
      if (pulse3) n_p3++;
    end
  endtask

  typedef struct {
    logic       en;
    logic [7:0] bus;
    logic       p2;
    logic [7:0] b2;
    logic       p3;
    logic [7:0] b3;
  } vec_t;

  vec_t tbl[6];
  sync_mode_e mode;

  initial begin
`ifdef DATA_SYNC_TOGGLE_EN
    mode = TOGGLE;
`else
    mode = LEVEL;
`endif
    $display("data_sync bench, mode=%s", mode.name());

    // Single transfer of 8'hA5: enable first sampled high at edge k (row 0).
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 8'hA5, 1'b1, 8'hA5, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 8'hA5, 1'b0, 8'hA5, 1'b1, 8'hA5};
    tbl[4] = '{1'b1, 8'hA5, 1'b0, 8'hA5, 1'b0, 8'hA5};
    tbl[5] = '{1'b1, 8'hA5, 1'b0, 8'hA5, 1'b0, 8'hA5};

    // Reset held with aggressive inputs.
    Drst_n     = 1'b0;
    unsync_bus = 8'hFF;
    bus_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_bus_n2",   {24'd0, sync_bus2}, 32'h0);
      check("rst_pulse_n2", {31'd0, pulse2},    32'h0);
      check("rst_bus_n3",   {24'd0, sync_bus3}, 32'h0);
      check("rst_pulse_n3", {31'd0, pulse3},    32'h0);
    end
    bus_enable = 1'b0;
    unsync_bus = 8'h00;
    Drst_n     = 1'b1;
    chk_on     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("idle_pulse_n2", {31'd0, pulse2}, 32'h0);
    end

    for (int i = 0; i < 6; i++) begin
      bus_enable = tbl[i].en;
      unsync_bus = tbl[i].bus;
      cyc();
      check($sformatf("tbl%0d_pulse_n2", i), {31'd0, pulse2},    {31'd0, tbl[i].p2});
      check($sformatf("tbl%0d_bus_n2", i),   {24'd0, sync_bus2}, {24'd0, tbl[i].b2});
      check($sformatf("tbl%0d_pulse_n3", i), {31'd0, pulse3},    {31'd0, tbl[i].p3});
      check($sformatf("tbl%0d_bus_n3", i),   {24'd0, sync_bus3}, {24'd0, tbl[i].b3});
    end

`ifndef DATA_SYNC_TOGGLE_EN
    // Held enable: bus changes mid-way, only the first value is captured.
    n_p2 = 0; n_p3 = 0;
    run(6,  1'b0, 8'h3C);
    run(10, 1'b1, 8'h3C);
    run(10, 1'b1, 8'hC3);
    run(6,  1'b0, 8'hC3);
    check("held_pulses_n2", n_p2, 1);
    check("held_pulses_n3", n_p3, 1);
    check("held_bus_n2", {24'd0, sync_bus2}, 32'h3C);
    check("held_bus_n3", {24'd0, sync_bus3}, 32'h3C);

    // Back-to-back transfers with three low cycles between.
    n_p2 = 0; n_p3 = 0; first_b2 = '0;
    run(6, 1'b0, 8'h11);
    run(2, 1'b1, 8'h11);
    run(3, 1'b0, 8'h11);
    run(2, 1'b1, 8'h22);
    run(6, 1'b0, 8'h22);
    check("b2b_pulses_n2", n_p2, 2);
    check("b2b_first_n2", {24'd0, first_b2}, 32'h11);
    check("b2b_bus_n2", {24'd0, sync_bus2}, 32'h22);
`else
    // Toggle mode: each level change carries one new word.
    run(8, 1'b0, 8'h00);
    n_p2 = 0; n_p3 = 0;
    run(6, 1'b1, 8'h5A);
    check("tog_rise_pulses_n2", n_p2, 1);
    check("tog_rise_pulses_n3", n_p3, 1);
    check("tog_rise_bus_n2", {24'd0, sync_bus2}, 32'h5A);
    check("tog_rise_bus_n3", {24'd0, sync_bus3}, 32'h5A);
    n_p2 = 0; n_p3 = 0;
    run(6, 1'b0, 8'hA5);
    check("tog_fall_pulses_n2", n_p2, 1);
    check("tog_fall_pulses_n3", n_p3, 1);
    check("tog_fall_bus_n2", {24'd0, sync_bus2}, 32'hA5);
    check("tog_fall_bus_n3", {24'd0, sync_bus3}, 32'hA5);
`endif

    // Reset mid-transfer; enable still high at release gives a fresh pulse.
    run(8, 1'b0, 8'h77);
    run(1, 1'b1, 8'h77);
    Drst_n = 1'b0;
    #1;
    check("midrst_bus_n2",   {24'd0, sync_bus2}, 32'h0);
    check("midrst_pulse_n2", {31'd0, pulse2},    32'h0);
    check("midrst_bus_n3",   {24'd0, sync_bus3}, 32'h0);
    cyc();
    check("midrst_hold_bus_n2", {24'd0, sync_bus2}, 32'h0);
    Drst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      check($sformatf("rel_e%0d_pulse_n2", i), {31'd0, pulse2}, {31'd0, (i == 3)});
      check($sformatf("rel_e%0d_pulse_n3", i), {31'd0, pulse3}, {31'd0, (i == 4)});
    end
    check("rel_bus_n2", {24'd0, sync_bus2}, 32'h77);
    check("rel_bus_n3", {24'd0, sync_bus3}, 32'h77);

    // Randomised traffic with occasional resets; the model checker compares every cycle.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus_enable = ~bus_enable;
      unsync_bus = 8'($urandom);
      Drst_n = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      cyc();
    end
    Drst_n = 1'b1;
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_sync.md
Name: data_sync

Overview:
- Parametrised bus synchroniser with qualifier handshake; next generation of the team's fixed 2-flop, 4-bit synchroniser.
- Passes only the 1-bit enable through an N-stage flop chain.
- Detects the enable's rising edge and captures the multi-bit bus once, so the bus itself never goes through the chain.
- Sits at every clock-domain entry (UART RX to system, register file to UART TX) in the destination domain.

Parameters:
- NUM_STAGES, 2, depth of the enable synchroniser chain; legal range 2..4.
- BUS_WIDTH, 8, width of the data bus being transferred.

Ports:
- Dclk  input  1  destination-domain clock.
- Drst_n  input  1  asynchronous active-low reset.
- unsync_bus  input  BUS_WIDTH  source-domain data. Held stable from before bus_enable rises until after enable_pulse.
- bus_enable  input  1  source-domain qualifier. Level mode: high while unsync_bus is valid.
- sync_bus  output  BUS_WIDTH  captured data. Registered; holds its last value between captures.
- enable_pulse  output  1  single-cycle strobe, aligned with each new sync_bus value.

Behaviour:
- Clock and reset: one clock, Dclk. Reset is asynchronous and active-low on Drst_n; assertion acts immediately, no clock needed.
- Reset state: sync chain all 0, edge flop 0, sync_bus = 0, enable_pulse = 0.
- Chain: stage[0] <= bus_enable; stage[i] <= stage[i-1]. sync_en = stage[NUM_STAGES-1].
- Edge detect: edge_ff <= sync_en; pulse_gen = sync_en & ~edge_ff (combinational, internal only).
- Capture:
  - if pulse_gen: sync_bus <= unsync_bus.
  - else: sync_bus holds.
  - enable_pulse <= pulse_gen.
- Latency: bus_enable sampled high at Dclk edge k -> sync_bus and enable_pulse update at edge k+NUM_STAGES. enable_pulse is high for exactly one cycle.
- Enable held high for many cycles: exactly one pulse, one capture.
- Enable low-high-low shorter than one Dclk period: may be missed. Source contract requires a high time of at least 2 Dclk periods; not detected in hardware.
- Back-to-back transfers: bus_enable must be low for at least NUM_STAGES+1 Dclk cycles between highs, otherwise the second pulse is lost.
- Reset mid-transfer: chain and outputs clear at once. A bus_enable still high after reset release produces a fresh pulse NUM_STAGES+1 edges after release.
- Elaboration: NUM_STAGES outside 2..4 is an elaboration error.

Optional Feature:
- Macro: DATA_SYNC_TOGGLE_EN.
- Defined (toggle mode):
  - bus_enable is a toggle; each level change signals new data.
  - pulse_gen = sync_en ^ edge_ff, so both edges capture.
  - Latency is unchanged.
  - Minimum spacing between toggles: NUM_STAGES+1 Dclk cycles.
- Undefined: level/rising-edge mode as above; falling edges ignored.

Decomposition:
- Package data_sync_pkg:
  - constants DATA_SYNC_MIN_STAGES = 2 and DATA_SYNC_MAX_STAGES = 4;
  - default BUS_WIDTH = 8;
  - enumerated mode type (LEVEL, TOGGLE) used by the bench for reporting.
- Sub-module bit_sync:
  - generic N-stage, WIDTH-bit flop chain with Dclk/Drst_n;
  - instantiated with WIDTH = 1 for the enable;
  - reusable for other single-bit crossings.

Test Plan:
- Reset, NUM_STAGES=2: hold Drst_n=0 for 3 cycles with unsync_bus=8'hFF and bus_enable=1 -> sync_bus=8'h00, enable_pulse=0 throughout.
- Single transfer: unsync_bus=8'hA5, bus_enable rises, sampled at edge k -> sync_bus=8'hA5 and enable_pulse=1 after edge k+2 only. Repeat with NUM_STAGES=3 -> after edge k+3.
- Held enable: bus_enable high for 20 cycles, unsync_bus changed 8'h3C->8'hC3 mid-way -> one pulse; sync_bus stays 8'h3C.
- Back-to-back: 8'h11 then 8'h22 with 3 low cycles between (NUM_STAGES=2) -> two pulses; sync_bus ends at 8'h22.
- Reset mid-transfer: Drst_n low one cycle after bus_enable rises, bus_enable still high at release -> outputs 0 during reset; one pulse 3 edges after release.
- DATA_SYNC_TOGGLE_EN: bus_enable toggles 0->1->0 at least 4 cycles apart with 8'h5A then 8'hA5 -> two pulses; sync_bus = 8'h5A, then 8'hA5.
